// File: rtl/float_pkg.sv
// Shared binary32 constants and the unpacked-operand types used by the FPU front end.
package float_pkg;

    localparam int EXP_W  = 8;    // packed exponent field width
    localparam int FRAC_W = 23;   // packed fraction field width
    localparam int MAN_W  = 24;   // unpacked mantissa, hidden bit included
    localparam int UEXP_W = 10;   // unbiased exponent, two's complement
    localparam int BIAS   = 127;

    localparam logic [2:0] RM_DYN = 3'b111;

    // One operand after classification and subnormal normalization.
    typedef struct packed {
        logic [MAN_W-1:0]  man;
        logic [UEXP_W-1:0] exp;
        logic              sgn;
        logic              zero;
        logic              inf;
        logic              sNaN;
        logic              qNaN;
    } unpacked_t;

    // Everything the buffer stores for one issued operation.
    typedef struct packed {
        logic [4:0] op;
        logic [2:0] rm;
        unpacked_t  a;
        unpacked_t  b;
    } entry_t;

    // The dynamic encoding defers to the CSR; any other value, legal or not, passes through.
    function automatic logic [2:0] resolve_rm(input logic [2:0] rm_in, input logic [2:0] frm);
        return (rm_in == RM_DYN) ? frm : rm_in;
    endfunction

endpackage

// File: rtl/float_unpack.sv
// Combinational binary32 unpacker: classifies the operand and normalizes subnormals
// with a leading-zero count and left shift so the hidden bit always lands at [23].
module float_unpack
    import float_pkg::*;
(
    input  logic [31:0] x,
    output unpacked_t   u
);

    logic [EXP_W-1:0]  e;
    logic [FRAC_W-1:0] f;
    logic [MAN_W-1:0]  sub;
    logic [4:0]        lz;

    assign e   = x[30:23];
    assign f   = x[22:0];
    assign sub = {1'b0, f};

    // Leading-zero count of the subnormal mantissa; the last (highest) set bit wins.
    always_comb begin
        // NOTE: give every combinational output a default before any branch so no latch is inferred.
        lz = 5'd0;
        for (int i = 0; i < MAN_W; i++) begin
            if (sub[i]) lz = 5'(MAN_W - 1 - i);
        end
    end

    // Classify and build mantissa/exponent; the sign passes through for every class.
    always_comb begin
        u     = '0;
        u.sgn = x[31];
        if (e == '0) begin
            if (f == '0) begin
                u.zero = 1'b1;
            end else begin
                u.man = sub << lz;
                u.exp = UEXP_W'(-126) - UEXP_W'(lz);
            end
        end else if (e == '1) begin
            u.man = {1'b1, f};
            u.exp = UEXP_W'(128);
            if (f == '0)      u.inf  = 1'b1;
            else if (f[22])   u.qNaN = 1'b1;
            else              u.sNaN = 1'b1;
        end else begin
            u.man = {1'b1, f};
            u.exp = UEXP_W'({2'b00, e}) - UEXP_W'(BIAS);
        end
    end

endmodule

// File: rtl/float_pre_processor.sv
// FPU operand pre-processor: unpacks both operands, resolves the rounding mode and
// presents the result through a two-entry (output + skid) valid/ready buffer.
module float_pre_processor
    import float_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        flush,
    input  logic        valid_in,
    output logic        ready_out,
    output logic        valid_out,
    input  logic        ready_in,
    input  logic [4:0]  op_in,
    input  logic [2:0]  rm_in,
    input  logic [2:0]  frm,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [4:0]  op,
    output logic [2:0]  rm,
    output logic [23:0] man_a,
    output logic [23:0] man_b,
    output logic [9:0]  exp_a,
    output logic [9:0]  exp_b,
    output logic        sgn_a,
    output logic        sgn_b,
    output logic        zero_a,
    output logic        zero_b,
    output logic        inf_a,
    output logic        inf_b,
    output logic        sNaN_a,
    output logic        sNaN_b,
    output logic        qNaN_a,
    output logic        qNaN_b
);

    unpacked_t ua, ub;
    entry_t    in_entry, out_q, skid_q;
    logic      out_valid, skid_valid, ready_q;
    logic      out_valid_d, skid_valid_d;
    logic      out_free, accept, load_out, load_skid, out_from_skid;

    float_unpack u_unpack_a (.x(a), .u(ua));
    float_unpack u_unpack_b (.x(b), .u(ub));

    assign in_entry = '{op: op_in, rm: resolve_rm(rm_in, frm), a: ua, b: ub};

    // Buffer control: decide what loads where and the next occupancy of both entries.
    always_comb begin
        out_free      = !out_valid || ready_in;
        accept        = valid_in && ready_q;
        out_valid_d   = out_valid;
        skid_valid_d  = skid_valid;
        load_out      = 1'b0;
        load_skid     = 1'b0;
        out_from_skid = 1'b0;
        if (flush) begin
            out_valid_d  = 1'b0;
            skid_valid_d = 1'b0;
        end else if (out_free) begin
            if (skid_valid) begin
                // Skid full implies ready_out was low, so no accept competes here.
                load_out      = 1'b1;
                out_from_skid = 1'b1;
                out_valid_d   = 1'b1;
                skid_valid_d  = 1'b0;
            end else if (accept) begin
                load_out    = 1'b1;
                out_valid_d = 1'b1;
            end else begin
                out_valid_d = 1'b0;
            end
        end else if (accept) begin
            load_skid    = 1'b1;
            skid_valid_d = 1'b1;
        end
    end

    // State and data registers; ready_out is registered as the inverse of next skid occupancy.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            // NOTE: data registers are reset too because the outputs must read zero during reset.
            out_valid  <= 1'b0;
            skid_valid <= 1'b0;
            ready_q    <= 1'b1;
            out_q      <= '0;
            skid_q     <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            out_valid  <= out_valid_d;
            skid_valid <= skid_valid_d;
            ready_q    <= !skid_valid_d;
            if (load_out)  out_q  <= out_from_skid ? skid_q : in_entry;
            if (load_skid) skid_q <= in_entry;
        end
    end

    assign ready_out = ready_q;
    assign valid_out = out_valid;
    assign op        = out_q.op;
    assign rm        = out_q.rm;
    assign man_a     = out_q.a.man;
    assign exp_a     = out_q.a.exp;
    assign sgn_a     = out_q.a.sgn;
    assign zero_a    = out_q.a.zero;
    assign inf_a     = out_q.a.inf;
    assign sNaN_a    = out_q.a.sNaN;
    assign qNaN_a    = out_q.a.qNaN;
    assign man_b     = out_q.b.man;
    assign exp_b     = out_q.b.exp;
    assign sgn_b     = out_q.b.sgn;
    assign zero_b    = out_q.b.zero;
    assign inf_b     = out_q.b.inf;
    assign sNaN_b    = out_q.b.sNaN;
    assign qNaN_b    = out_q.b.qNaN;

endmodule

// File: tb/tb_float_pre_processor.sv
// Self-checking bench for float_pre_processor: directed vector table, backpressure,
// flush and reset sequences, then randomized traffic against a scoreboard model.
module tb_float_pre_processor;

    logic        clk = 1'b0;
    logic        reset, flush, valid_in, ready_in;
    logic        ready_out, valid_out;
    logic [4:0]  op_in, op;
    logic [2:0]  rm_in, frm, rm;
    logic [31:0] a, b;
    logic [23:0] man_a, man_b;
    logic [9:0]  exp_a, exp_b;
    logic        sgn_a, sgn_b, zero_a, zero_b, inf_a, inf_b;
    logic        sNaN_a, sNaN_b, qNaN_a, qNaN_b;

    int n_vec  = 0;
    int n_fail = 0;

    float_pre_processor dut (
        .clk(clk), .reset(reset), .flush(flush),
        .valid_in(valid_in), .ready_out(ready_out),
        .valid_out(valid_out), .ready_in(ready_in),
        .op_in(op_in), .rm_in(rm_in), .frm(frm), .a(a), .b(b),
        .op(op), .rm(rm),
        .man_a(man_a), .man_b(man_b), .exp_a(exp_a), .exp_b(exp_b),
        .sgn_a(sgn_a), .sgn_b(sgn_b), .zero_a(zero_a), .zero_b(zero_b),
        .inf_a(inf_a), .inf_b(inf_b), .sNaN_a(sNaN_a), .sNaN_b(sNaN_b),
        .qNaN_a(qNaN_a), .qNaN_b(qNaN_b)
    );

    always #5 clk = ~clk;

    // Operand view: {man[23:0], exp[9:0], sgn, zero, inf, sNaN, qNaN}
    function automatic logic [38:0] ref_unpack(input logic [31:0] x);
        int e, f, m, ex;
        logic z, i, s, q;
        logic [31:0] mv, ev;
        e = int'(x[30:23]);
        f = int'(x[22:0]);
        z = 0; i = 0; s = 0; q = 0;
        if (e == 0 && f == 0) begin
            m = 0; ex = 0; z = 1;
        end else if (e == 0) begin
            m = f; ex = -126;
            while (m < 8388608) begin
                m  = m * 2;
                ex = ex - 1;
            end
        end else if (e == 255) begin
            m = 8388608 + f; ex = 128;
            if (f == 0)            i = 1;
            else if (f >= 4194304) q = 1;
            else                   s = 1;
        end else begin
            m = 8388608 + f; ex = e - 127;
        end
        mv = m;
        ev = ex;
        return {mv[23:0], ev[9:0], x[31], z, i, s, q};
    endfunction

    // Whole operation view: {op, rm, a-operand, b-operand}
    function automatic logic [85:0] ref_op(input logic [4:0] o, input logic [2:0] r,
                                           input logic [2:0] f, input logic [31:0] xa,
                                           input logic [31:0] xb);
        logic [2:0] rr;
        rr = (r == 3'd7) ? f : r;
        return {o, rr, ref_unpack(xa), ref_unpack(xb)};
    endfunction

    function automatic logic [38:0] dut_a();
        return {man_a, exp_a, sgn_a, zero_a, inf_a, sNaN_a, qNaN_a};
    endfunction

    function automatic logic [38:0] dut_b();
        return {man_b, exp_b, sgn_b, zero_b, inf_b, sNaN_b, qNaN_b};
    endfunction

    function automatic logic [85:0] dut_all();
        return {op, rm, dut_a(), dut_b()};
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [4:0] o, input logic [31:0] xa,
                         input logic [31:0] xb, input logic [2:0] r, input logic [2:0] f);
        valid_in = v; op_in = o; a = xa; b = xb; rm_in = r; frm = f;
    endtask

    typedef struct {
        logic [31:0] a, b;
        logic [2:0]  rm_in, frm;
        logic [38:0] exp_a_op, exp_b_op;
        logic [2:0]  exp_rm;
    } vec_t;

    vec_t vt[7];
    logic [85:0] sb[$];
    logic [85:0] x_op, y_op, z_op;

    initial begin
        reset = 1'b1; flush = 1'b0; ready_in = 1'b0;
        drive(1'b0, 5'd0, 32'd0, 32'd0, 3'd0, 3'd0);

        // Hand-derived expectations (no model): {man, exp, sgn, zero, inf, sNaN, qNaN}
        vt[0] = '{32'h3F800000, 32'hC0000000, 3'd0, 3'd0,
                  {24'h800000, 10'h000, 5'b00000}, {24'h800000, 10'h001, 5'b10000}, 3'd0};
        vt[1] = '{32'h00000001, 32'h00400000, 3'd7, 3'd2,
                  {24'h800000, 10'h36B, 5'b00000}, {24'h800000, 10'h381, 5'b00000}, 3'd2};
        vt[2] = '{32'h80000000, 32'h7F800000, 3'd1, 3'd4,
                  {24'h000000, 10'h000, 5'b11000}, {24'h800000, 10'h080, 5'b00100}, 3'd1};
        vt[3] = '{32'h7FC00000, 32'h7F800001, 3'd5, 3'd3,
                  {24'hC00000, 10'h080, 5'b00001}, {24'h800001, 10'h080, 5'b00010}, 3'd5};
        vt[4] = '{32'hFFFFFFFF, 32'h00000000, 3'd7, 3'd6,
                  {24'hFFFFFF, 10'h080, 5'b10001}, {24'h000000, 10'h000, 5'b01000}, 3'd6};
        vt[5] = '{32'h007FFFFF, 32'h7F7FFFFF, 3'd3, 3'd7,
                  {24'hFFFFFE, 10'h381, 5'b00000}, {24'hFFFFFF, 10'h07F, 5'b00000}, 3'd3};
        vt[6] = '{32'h00800000, 32'h80000001, 3'd4, 3'd1,
                  {24'h800000, 10'h382, 5'b00000}, {24'h800000, 10'h36B, 5'b10000}, 3'd4};

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_valid_out", 128'(valid_out), 128'd0);
        check("reset_ready_out", 128'(ready_out), 128'd1);
        check("reset_data", 128'(dut_all()), 128'd0);
        reset = 1'b0;

        // Directed vector table, back-to-back with ready_in high
        ready_in = 1'b1;
        for (int k = 0; k < 7; k++) begin
            @(negedge clk);
            drive(1'b1, 5'(k + 3), vt[k].a, vt[k].b, vt[k].rm_in, vt[k].frm);
            @(posedge clk); #1;
            check($sformatf("vec%0d_valid", k), 128'(valid_out), 128'd1);
            check($sformatf("vec%0d_a", k), 128'(dut_a()), 128'(vt[k].exp_a_op));
            check($sformatf("vec%0d_b", k), 128'(dut_b()), 128'(vt[k].exp_b_op));
            check($sformatf("vec%0d_oprm", k), 128'({op, rm}), 128'({5'(k + 3), vt[k].exp_rm}));
        end
        @(negedge clk);
        drive(1'b0, 5'd0, 32'd0, 32'd0, 3'd0, 3'd0);
        @(negedge clk);
        check("idle_valid_out", 128'(valid_out), 128'd0);

        // Backpressure: X held, Y in skid, Z waits, then all three drain in order
        x_op = ref_op(5'd1, 3'd0, 3'd0, 32'h3F800000, 32'h40000000);
        y_op = ref_op(5'd2, 3'd1, 3'd0, 32'h00000001, 32'h7F800000);
        z_op = ref_op(5'd3, 3'd7, 3'd4, 32'hBF800000, 32'h7FC00000);
        ready_in = 1'b0;
        drive(1'b1, 5'd1, 32'h3F800000, 32'h40000000, 3'd0, 3'd0);
        @(negedge clk);
        check("bp_x_out", 128'(dut_all()), 128'(x_op));
        check("bp_ready_after_x", 128'(ready_out), 128'd1);
        drive(1'b1, 5'd2, 32'h00000001, 32'h7F800000, 3'd1, 3'd0);
        @(negedge clk);
        check("bp_ready_after_y", 128'(ready_out), 128'd0);
        check("bp_x_held", 128'(dut_all()), 128'(x_op));
        drive(1'b1, 5'd3, 32'hBF800000, 32'h7FC00000, 3'd7, 3'd4);
        @(negedge clk);
        check("bp_z_waits", 128'({valid_out, ready_out}), 128'(2'b10));
        check("bp_x_still", 128'(dut_all()), 128'(x_op));
        ready_in = 1'b1;
        @(negedge clk);
        check("bp_y_out", 128'(dut_all()), 128'(y_op));
        check("bp_ready_back", 128'(ready_out), 128'd1);
        @(negedge clk);
        check("bp_z_out", 128'(dut_all()), 128'(z_op));
        check("bp_z_valid", 128'(valid_out), 128'd1);
        valid_in = 1'b0;
        @(negedge clk);
        check("bp_no_dup", 128'(valid_out), 128'd0);

        // Flush with both entries full plus a same-cycle offer
        ready_in = 1'b0;
        drive(1'b1, 5'd4, 32'h3F800000, 32'h3F800000, 3'd0, 3'd0);
        @(negedge clk);
        drive(1'b1, 5'd5, 32'h40000000, 32'h40000000, 3'd0, 3'd0);
        @(negedge clk);
        check("fl_full", 128'({valid_out, ready_out}), 128'(2'b10));
        flush = 1'b1;
        drive(1'b1, 5'd6, 32'h40400000, 32'h40400000, 3'd0, 3'd0);
        @(negedge clk);
        check("fl_cleared", 128'({valid_out, ready_out}), 128'(2'b01));
        flush = 1'b0;
        valid_in = 1'b0;
        ready_in = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("fl_no_stale", 128'(valid_out), 128'd0);
        end

        // Asynchronous reset mid-stall, observed before the next rising edge
        ready_in = 1'b0;
        drive(1'b1, 5'd7, 32'h3F800000, 32'h3F800000, 3'd0, 3'd0);
        @(negedge clk);
        drive(1'b1, 5'd8, 32'h40000000, 32'h40000000, 3'd0, 3'd0);
        @(negedge clk);
        valid_in = 1'b0;
        #1 reset = 1'b1;
        #1;
        check("rst_async_ctl", 128'({valid_out, ready_out}), 128'(2'b01));
        check("rst_async_data", 128'(dut_all()), 128'd0);
        @(negedge clk);
        reset = 1'b0;

        // Randomized traffic against the scoreboard
        for (int cyc = 0; cyc < 2000; cyc++) begin
            logic [31:0] ra, rb;
            @(negedge clk);
            ra = $urandom;
            rb = $urandom;
            case ($urandom_range(0, 5))
                0: ra[30:23] = 8'h00;
                1: ra[30:23] = 8'hFF;
                2: rb[30:23] = 8'h00;
                3: rb[30:23] = 8'hFF;
                default: ;
            endcase
            if ($urandom_range(0, 7) == 0) ra[22:0] = 23'(1) << $urandom_range(0, 22);
            flush    = ($urandom_range(0, 49) == 0);
            ready_in = flush ? 1'b0 : ($urandom_range(0, 2) != 0);
            drive($urandom_range(0, 3) != 0, 5'($urandom), ra, rb, 3'($urandom), 3'($urandom));
            #1;
            if (valid_out) begin
                if (sb.size() == 0) check("rnd_unexpected_output", 128'(valid_out), 128'd0);
                else                check("rnd_output", 128'(dut_all()), 128'(sb[0]));
            end
            if (flush) begin
                sb.delete();
            end else begin
                if (valid_out && ready_in && sb.size() > 0) void'(sb.pop_front());
                if (valid_in && ready_out) sb.push_back(ref_op(op_in, rm_in, frm, a, b));
            end
        end

        // Drain with a bounded budget
        @(negedge clk);
        flush = 1'b0;
        valid_in = 1'b0;
        ready_in = 1'b1;
        for (int cyc = 0; cyc < 10 && sb.size() > 0; cyc++) begin
            #1;
            if (valid_out) begin
                check("drain_output", 128'(dut_all()), 128'(sb[0]));
                void'(sb.pop_front());
            end
            @(negedge clk);
        end
        check("drain_empty", 128'(sb.size()), 128'd0);
        #1;
        check("drain_valid_low", 128'(valid_out), 128'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
